// File: rtl/pmp_seq_checker_pkg.sv
// rtl/pmp_seq_checker_pkg.sv - shared constants and types for the sequential PMP checker
//
// Purpose: PMP address-matching mode codes, cfg-byte bit positions,
// access-type bit positions and the checker FSM state type.
// Ports: none (package).

package pmp_seq_checker_pkg;

  // cfg[4:3] address-matching modes
  localparam logic [1:0] PMP_OFF   = 2'b00;
  localparam logic [1:0] PMP_TOR   = 2'b01;
  localparam logic [1:0] PMP_NA4   = 2'b10;
  localparam logic [1:0] PMP_NAPOT = 2'b11;

  // cfg byte bit positions
  localparam int CFG_R    = 0;
  localparam int CFG_W    = 1;
  localparam int CFG_X    = 2;
  localparam int CFG_A_LO = 3;
  localparam int CFG_A_HI = 4;
  localparam int CFG_L    = 7;

  // ReqType one-hot bit positions {X,W,R}
  localparam int ACC_R = 0;
  localparam int ACC_W = 1;
  localparam int ACC_X = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/pmp_range_lane.sv
// rtl/pmp_range_lane.sv - combinational range and permission evaluation for one PMP entry
//
// Purpose: derives the entry's byte region [base, top) and classifies the
// access range [Lo, Hi] as overlapping (AnyMatch) or fully contained (FullMatch).
// Ports:
//   Lo, Hi     in  access first/last byte address, PA_BITS+1 wide
//   Cfg        in  entry cfg byte
//   Adr        in  entry pmpaddr value
//   AdrPrev    in  previous entry pmpaddr value (TOR base)
//   IsEntry0   in  entry is index 0 (TOR base is 0)
//   AnyMatch   out access overlaps the region
//   FullMatch  out access lies entirely inside the region
//   L/X/W/R    out cfg lock and permission bits

module pmp_range_lane
  import pmp_seq_checker_pkg::*;
#(
  parameter int PA_BITS = 34
) (
  input  logic [PA_BITS:0]   Lo,
  input  logic [PA_BITS:0]   Hi,
  input  logic [7:0]         Cfg,
  input  logic [PA_BITS-3:0] Adr,
  input  logic [PA_BITS-3:0] AdrPrev,
  input  logic               IsEntry0,
  output logic               AnyMatch,
  output logic               FullMatch,
  output logic               L,
  output logic               X,
  output logic               W,
  output logic               R
);

  logic [1:0]         mode;
  logic [PA_BITS-3:0] tmask;
  logic [PA_BITS-1:0] mask;
  logic [PA_BITS:0]   base;
  logic [PA_BITS:0]   top;
  logic               nonempty;
  logic               unused_cfg;

  assign mode = Cfg[CFG_A_HI:CFG_A_LO];

  // NAPOT mask: a pmpaddr bit belongs to the size field when every bit
  // below it is 1. Bit 0 is always in the field (either a 1 or the
  // terminating 0), so an all-ones pmpaddr covers the whole space.
  always_comb begin
    tmask    = '0;
    tmask[0] = 1'b1;
    for (int j = 1; j < PA_BITS - 2; j++) begin
      tmask[j] = tmask[j-1] & Adr[j-1];
    end
  end

  always_comb begin
    mask     = (mode == PMP_NAPOT) ? {tmask, 2'b11} : {{(PA_BITS-2){1'b0}}, 2'b11};
    base     = '0;
    top      = '0;
    nonempty = 1'b0;
    case (mode)
      PMP_TOR: begin
        base     = IsEntry0 ? '0 : {1'b0, AdrPrev, 2'b00};
        top      = {1'b0, Adr, 2'b00};
        nonempty = (base < top);
      end
      PMP_NA4, PMP_NAPOT: begin
        // one extra bit of width keeps a whole-space region's top from wrapping to 0
        base     = {1'b0, {Adr, 2'b00} & ~mask};
        top      = base + {1'b0, mask} + (PA_BITS+1)'(1);
        nonempty = 1'b1;
      end
      default: ;
    endcase
  end

  assign AnyMatch  = nonempty && (Lo < top) && (Hi >= base);
  assign FullMatch = nonempty && (Lo >= base) && (Hi < top);

  assign L = Cfg[CFG_L];
  assign X = Cfg[CFG_X];
  assign W = Cfg[CFG_W];
  assign R = Cfg[CFG_R];

  assign unused_cfg = ^Cfg[6:5];

endmodule

// File: rtl/pmp_seq_checker.sv
// rtl/pmp_seq_checker.sv - multi-cycle PMP checker scanning LANES entries per cycle
//
// Purpose: checks a full access (address + size) against all PMP entries,
// lowest-index overlapping entry wins, partial overlap faults.
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   ReqValid/ReqReady      request handshake
//   ReqAdr/Size/Type/PrivM access start, log2 bytes, {X,W,R} one-hot, M-mode
//   PMPCfg, PMPAdr         packed cfg bytes and pmpaddr values
//   PMPUpdate              CSR write pulse, restarts an in-flight scan
//   RespValid/RespReady    response handshake
//   RespFault/Hit/Idx      access fault, some entry matched, winning entry

module pmp_seq_checker
  import pmp_seq_checker_pkg::*;
#(
  parameter int PA_BITS     = 34,
  parameter int PMP_ENTRIES = 16,
  parameter int LANES       = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ReqValid,
  output logic                              ReqReady,
  input  logic [PA_BITS-1:0]                ReqAdr,
  input  logic [1:0]                        ReqSize,
  input  logic [2:0]                        ReqType,
  input  logic                              ReqPrivM,
  input  logic [8*PMP_ENTRIES-1:0]          PMPCfg,
  input  logic [(PA_BITS-2)*PMP_ENTRIES-1:0] PMPAdr,
  input  logic                              PMPUpdate,
  output logic                              RespValid,
  input  logic                              RespReady,
  output logic                              RespFault,
  output logic                              RespHit,
  output logic [$clog2(PMP_ENTRIES)-1:0]    RespIdx
);

  localparam int GROUPS = PMP_ENTRIES / LANES;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int IW     = $clog2(PMP_ENTRIES);
  localparam int AW     = PA_BITS - 2;
  localparam logic [GW-1:0] LAST_G = GW'(GROUPS - 1);

  state_t             state, state_n;
  logic [GW-1:0]      g;
  logic               done;
  logic [PA_BITS-1:0] req_adr;
  logic [1:0]         req_size;
  logic [2:0]         req_type;
  logic               req_privm;
  logic               res_fault;
  logic               res_hit;
  logic [IW-1:0]      res_idx;

  logic [7:0]    cfg_arr [PMP_ENTRIES];
  logic [AW-1:0] adr_arr [PMP_ENTRIES];

  for (genvar e = 0; e < PMP_ENTRIES; e++) begin : g_unpack
    assign cfg_arr[e] = PMPCfg[8*e +: 8];
    assign adr_arr[e] = PMPAdr[AW*e +: AW];
  end

  // access range, one bit wider so a wrap past the top is visible
  logic [2:0]       span;
  logic [PA_BITS:0] lo;
  logic [PA_BITS:0] hi;
  logic             wrap;

  always_comb begin
    case (req_size)
      2'd0:    span = 3'd0;
      2'd1:    span = 3'd1;
      2'd2:    span = 3'd3;
      default: span = 3'd7;
    endcase
  end

  assign lo   = {1'b0, req_adr};
  assign hi   = lo + {{(PA_BITS-2){1'b0}}, span};
  assign wrap = hi[PA_BITS];

  // lanes for the current group
  logic [IW-1:0]    lane_idx [LANES];
  logic [LANES-1:0] lane_any;
  logic [LANES-1:0] lane_fault;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IW-1:0] prev_idx;
    logic          lane_full;
    logic          pl, px, pw, pr;
    logic          perm_ok;

    assign lane_idx[l] = IW'(int'(g) * LANES + l);
    assign prev_idx    = (lane_idx[l] == '0) ? '0 : lane_idx[l] - IW'(1);

    pmp_range_lane #(
      .PA_BITS(PA_BITS)
    ) u_lane (
      .Lo        (lo),
      .Hi        (hi),
      .Cfg       (cfg_arr[lane_idx[l]]),
      .Adr       (adr_arr[lane_idx[l]]),
      .AdrPrev   (adr_arr[prev_idx]),
      .IsEntry0  (lane_idx[l] == '0),
      .AnyMatch  (lane_any[l]),
      .FullMatch (lane_full),
      .L         (pl),
      .X         (px),
      .W         (pw),
      .R         (pr)
    );

    assign perm_ok = |(req_type & {px, pw, pr});
    // partial overlap always faults; M-mode bypasses permissions unless locked
    assign lane_fault[l] = !lane_full || ((!req_privm || pl) && !perm_ok);
  end

  // priority: walk high to low so the lowest matching lane is written last
  logic          hit_any;
  logic          win_fault;
  logic [IW-1:0] win_idx;
  logic          decide;

  always_comb begin
    hit_any   = 1'b0;
    win_fault = 1'b0;
    win_idx   = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (lane_any[l]) begin
        hit_any   = 1'b1;
        win_fault = lane_fault[l];
        win_idx   = lane_idx[l];
      end
    end
  end

  assign decide = wrap || hit_any || (g == LAST_G);

  // FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // the decided result sits in the result register for one cycle (done)
  // before RESP is entered
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (ReqValid)              state_n = S_SCAN;
      S_SCAN: if (!PMPUpdate && done)    state_n = S_RESP;
      S_RESP: if (RespReady)             state_n = S_IDLE;
      default:                           state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g         <= '0;
      done      <= 1'b0;
      req_adr   <= '0;
      req_size  <= '0;
      req_type  <= '0;
      req_privm <= 1'b0;
      res_fault <= 1'b0;
      res_hit   <= 1'b0;
      res_idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ReqValid) begin
            req_adr   <= ReqAdr;
            req_size  <= ReqSize;
            req_type  <= ReqType;
            req_privm <= ReqPrivM;
            g         <= '0;
            done      <= 1'b0;
            res_fault <= 1'b0;
            res_hit   <= 1'b0;
            res_idx   <= '0;
          end
        end
        S_SCAN: begin
          if (PMPUpdate) begin
            // CSRs changed under us: drop whatever was found and start over
            g         <= '0;
            done      <= 1'b0;
            res_fault <= 1'b0;
            res_hit   <= 1'b0;
            res_idx   <= '0;
          end else if (!done) begin
            if (decide) begin
              done <= 1'b1;
              if (wrap) begin
                res_fault <= 1'b1;
                res_hit   <= 1'b0;
                res_idx   <= '0;
              end else if (hit_any) begin
                res_fault <= win_fault;
                res_hit   <= 1'b1;
                res_idx   <= win_idx;
              end else begin
                res_fault <= !req_privm;
                res_hit   <= 1'b0;
                res_idx   <= '0;
              end
            end else begin
              g <= g + GW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ReqReady  = (state == S_IDLE) && reset;
  assign RespValid = (state == S_RESP);
  assign RespFault = res_fault;
  assign RespHit   = res_hit;
  assign RespIdx   = res_idx;

endmodule

// File: tb/tb_pmp_seq_checker.sv
// tb/tb_pmp_seq_checker.sv - self-checking bench for pmp_seq_checker

module tb_pmp_seq_checker;

  logic         clk = 1'b0;
  logic         reset;
  logic         ReqValid;
  logic         ReqReady;
  logic [33:0]  ReqAdr;
  logic [1:0]   ReqSize;
  logic [2:0]   ReqType;
  logic         ReqPrivM;
  logic [127:0] PMPCfg;
  logic [511:0] PMPAdr;
  logic         PMPUpdate;
  logic         RespValid;
  logic         RespReady;
  logic         RespFault;
  logic         RespHit;
  logic [3:0]   RespIdx;

  logic [7:0]  cfg_a [16];
  logic [31:0] adr_a [16];

  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_fault;
  logic exp_hit;
  int   exp_idx;

  localparam logic [2:0] T_R = 3'b001;
  localparam logic [2:0] T_W = 3'b010;
  localparam logic [2:0] T_X = 3'b100;

  pmp_seq_checker dut (
    .clk       (clk),
    .reset     (reset),
    .ReqValid  (ReqValid),
    .ReqReady  (ReqReady),
    .ReqAdr    (ReqAdr),
    .ReqSize   (ReqSize),
    .ReqType   (ReqType),
    .ReqPrivM  (ReqPrivM),
    .PMPCfg    (PMPCfg),
    .PMPAdr    (PMPAdr),
    .PMPUpdate (PMPUpdate),
    .RespValid (RespValid),
    .RespReady (RespReady),
    .RespFault (RespFault),
    .RespHit   (RespHit),
    .RespIdx   (RespIdx)
  );

  always #5 clk = ~clk;

  always_comb begin
    PMPCfg = '0;
    PMPAdr = '0;
    for (int i = 0; i < 16; i++) begin
      PMPCfg[8*i +: 8]  = cfg_a[i];
      PMPAdr[32*i +: 32] = adr_a[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: byte regions as plain integers, first overlapping entry wins.
  function automatic void model(input logic [33:0] a, input logic [1:0] sz, input logic [2:0] t,
                                input logic pm, output logic f, output logic h,
                                output int idx, output int grp);
    longint lo, hi, base, top, rsz;
    int     k;
    bit     found;
    logic   full, perm;
    lo = longint'(a);
    hi = lo + (longint'(1) << sz) - 1;
    f = 1'b0; h = 1'b0; idx = 0; grp = 3; found = 0; full = 1'b0; perm = 1'b0;
    if (hi >= (longint'(1) << 34)) begin
      f = 1'b1; grp = 0;
      return;
    end
    for (int i = 0; i < 16 && !found; i++) begin
      base = 0; top = 0;
      case (cfg_a[i][4:3])
        2'b01: begin
          if (i > 0) base = longint'(adr_a[i-1]) * 4;
          top = longint'(adr_a[i]) * 4;
        end
        2'b10: begin
          base = longint'(adr_a[i]) * 4;
          top  = base + 4;
        end
        2'b11: begin
          k = 0;
          while (k < 32 && adr_a[i][k]) k++;
          rsz  = longint'(1) << (k + 3);
          base = (longint'(adr_a[i]) * 4) & ~(rsz - 1);
          top  = base + rsz;
        end
        default: ;
      endcase
      if (base < top && lo < top && hi >= base) begin
        found = 1;
        idx   = i;
        full  = (lo >= base) && (hi < top);
        case (t)
          T_R:     perm = cfg_a[i][0];
          T_W:     perm = cfg_a[i][1];
          T_X:     perm = cfg_a[i][2];
          default: perm = 1'b0;
        endcase
        if (!full)                    f = 1'b1;
        else if (!pm || cfg_a[i][7])  f = !perm;
        else                          f = 1'b0;
      end
    end
    h = found;
    if (found) grp = idx / 4;
    else       f = !pm;
  endfunction

  // Response checker: every cycle a response is presented it must equal the model.
  always @(negedge clk) begin
    if (reset && RespValid) begin
      chk("resp_fault", RespFault, exp_fault);
      chk("resp_hit", RespHit, exp_hit);
      chk("resp_idx", RespIdx, exp_idx);
      chk("req_ready_in_resp", ReqReady, 0);
    end
  end

  task automatic clear_pmp();
    for (int i = 0; i < 16; i++) begin
      cfg_a[i] = 8'h00;
      adr_a[i] = 32'h0;
    end
  endtask

  task automatic do_req(input string name, input logic [33:0] a, input logic [1:0] sz,
                        input logic [2:0] t, input logic pm, input bit upd, input int hold,
                        input logic e_fault, input logic e_hit, input int e_idx, input int e_lat);
    logic mf, mh;
    int   mi, mg, lat;
    model(a, sz, t, pm, mf, mh, mi, mg);
    chk({name, "_model_fault"}, mf, e_fault);
    chk({name, "_model_hit"}, mh, e_hit);
    chk({name, "_model_idx"}, mi, e_idx);
    chk({name, "_model_latency"}, mg + 2 + (upd ? 2 : 0), e_lat);
    exp_fault = mf;
    exp_hit   = mh;
    exp_idx   = mi;
    chk({name, "_req_ready"}, ReqReady, 1);
    ReqAdr   = a;
    ReqSize  = sz;
    ReqType  = t;
    ReqPrivM = pm;
    ReqValid = 1'b1;
    @(posedge clk); #1;
    ReqValid = 1'b0;
    lat = 0;
    while (!RespValid && lat < 20) begin
      if (upd && lat == 1) PMPUpdate = 1'b1;
      @(posedge clk); #1;
      PMPUpdate = 1'b0;
      lat++;
    end
    chk({name, "_latency"}, lat, e_lat);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    RespReady = 1'b1;
    @(posedge clk); #1;
    RespReady = 1'b0;
    chk({name, "_resp_dropped"}, RespValid, 0);
    chk({name, "_back_to_idle"}, ReqReady, 1);
  endtask

  initial begin
    reset     = 1'b0;
    ReqValid  = 1'b0;
    ReqAdr    = '0;
    ReqSize   = '0;
    ReqType   = '0;
    ReqPrivM  = 1'b0;
    PMPUpdate = 1'b0;
    RespReady = 1'b0;
    exp_fault = 1'b0;
    exp_hit   = 1'b0;
    exp_idx   = 0;
    clear_pmp();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", ReqReady, 0);
    chk("rst_resp_valid", RespValid, 0);
    chk("rst_resp_fault", RespFault, 0);
    chk("rst_resp_hit", RespHit, 0);
    chk("rst_resp_idx", RespIdx, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req_ready", ReqReady, 1);

    // NAPOT 4 KiB at 0x8000_0000 RWX, 8-byte read ending at the last byte
    clear_pmp();
    cfg_a[0] = 8'h1F; adr_a[0] = 32'h2000_01FF;
    do_req("napot_full", 34'h0_8000_0FF8, 2'd3, T_R, 1'b0, 0, 1, 1'b0, 1'b1, 0, 2);

    // NA4 at 0xC, 8-byte read at 0x8 straddles the start
    clear_pmp();
    cfg_a[3] = 8'h11; adr_a[3] = 32'h3;
    do_req("na4_partial", 34'h8, 2'd3, T_R, 1'b0, 0, 0, 1'b1, 1'b1, 3, 2);

    // last entry TOR [0x1000,0x2000) write-only
    clear_pmp();
    adr_a[14] = 32'h400; adr_a[15] = 32'h800; cfg_a[15] = 8'h0A;
    do_req("tor_last", 34'h1FFC, 2'd2, T_W, 1'b0, 0, 0, 1'b0, 1'b1, 15, 5);

    // nothing enabled
    clear_pmp();
    do_req("off_m", 34'h0, 2'd0, T_R, 1'b1, 0, 1, 1'b0, 1'b0, 0, 5);
    do_req("off_u", 34'h0, 2'd0, T_R, 1'b0, 0, 0, 1'b1, 1'b0, 0, 5);

    // locked TOR read-only binds M-mode; unlocked does not
    clear_pmp();
    adr_a[0] = 32'h40; cfg_a[0] = 8'h89;
    do_req("tor_locked", 34'h80, 2'd0, T_W, 1'b1, 0, 0, 1'b1, 1'b1, 0, 2);
    cfg_a[0] = 8'h09;
    do_req("tor_unlocked", 34'h80, 2'd0, T_W, 1'b1, 0, 0, 1'b0, 1'b1, 0, 2);

    // hit in group 2, then the same with a CSR write in the second scan cycle
    clear_pmp();
    adr_a[9] = 32'h40; cfg_a[9] = 8'h13;
    do_req("grp2", 34'h100, 2'd2, T_R, 1'b0, 0, 0, 1'b0, 1'b1, 9, 4);
    do_req("grp2_update", 34'h100, 2'd2, T_R, 1'b0, 1, 0, 1'b0, 1'b1, 9, 6);

    // empty TOR skipped, whole-space NAPOT covers the top of memory
    clear_pmp();
    adr_a[4] = 32'h100; adr_a[5] = 32'h80; cfg_a[5] = 8'h0F;
    adr_a[6] = 32'h7FFF_FFFF; cfg_a[6] = 8'h1F;
    do_req("whole_space", 34'h3_FFFF_FFF8, 2'd3, T_X, 1'b0, 0, 2, 1'b0, 1'b1, 6, 3);

    // wrap past the top faults even with a covering entry and M-mode
    clear_pmp();
    adr_a[0] = 32'h7FFF_FFFF; cfg_a[0] = 8'h1F;
    do_req("wrap", 34'h3_FFFF_FFFC, 2'd3, T_R, 1'b1, 0, 0, 1'b1, 1'b0, 0, 2);

    // reset in the middle of a scan
    clear_pmp();
    ReqAdr = 34'h0; ReqSize = 2'd0; ReqType = T_R; ReqPrivM = 1'b0;
    ReqValid = 1'b1;
    @(posedge clk); #1;
    ReqValid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_resp_valid", RespValid, 0);
    chk("mid_rst_req_ready", ReqReady, 0);
    @(posedge clk); #1;
    chk("mid_rst_held_valid", RespValid, 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_release_ready", ReqReady, 1);
    @(posedge clk); #1;
    chk("mid_rst_idle_valid", RespValid, 0);
    chk("mid_rst_idle_ready", ReqReady, 1);
    do_req("after_rst", 34'h0, 2'd0, T_R, 1'b0, 0, 0, 1'b1, 1'b0, 0, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

endmodule

// File: doc/pmp_seq_checker.md
Name: pmp_seq_checker

Overview:
Multi-cycle PMP checker that evaluates a full physical access (address plus size) against all PMP entries. It scans LANES entries per cycle and resolves priority, with the lowest-numbered matching entry winning. Unlike the single-entry decoder, it rejects accesses that only partially overlap the matching region, which closes the access-size hole. It sits between the LSU/IFU request path and the access-fault logic, and uses a valid/ready handshake on both sides.

Parameters:
PA_BITS, 34, physical address width
PMP_ENTRIES, 16, number of PMP entries (multiple of LANES, ≥ LANES)
LANES, 4, entries evaluated per scan cycle
GROUPS, PMP_ENTRIES/LANES, derived localparam, not overridable

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low; state clears immediately while 0
ReqValid  in  1  request offered
ReqReady  out  1  block can accept a request
ReqAdr  in  PA_BITS  access start byte address
ReqSize  in  2  log2 of access bytes (0..3 = 1..8 bytes)
ReqType  in  3  {X,W,R} one-hot access type
ReqPrivM  in  1  effective privilege is Machine
PMPCfg  in  8*PMP_ENTRIES  packed cfg bytes; entry i at [8i+7:8i]
PMPAdr  in  (PA_BITS-2)*PMP_ENTRIES  packed pmpaddr values
PMPUpdate  in  1  pulse on any pmpcfg/pmpaddr CSR write
RespValid  out  1  result available
RespReady  in  1  consumer takes result
RespFault  out  1  access fault
RespHit  out  1  some entry matched (fully or partially)
RespIdx  out  log2(PMP_ENTRIES)  winning entry index; 0 if !RespHit

Behaviour:
- Reset values: ReqReady=0 while reset is asserted and 1 in IDLE after release. RespValid, RespFault, RespHit and RespIdx are all 0. State is IDLE and the group counter is 0.
- FSM IDLE: ReqReady=1. On ReqValid, latch Adr/Size/Type/PrivM, clear the group counter and go to SCAN.
- FSM SCAN: ReqReady=0. Evaluate entries g*LANES .. g*LANES+LANES-1.
  - If any lane hits, or g==GROUPS-1, register the result and go to RESP.
  - Otherwise increment g.
- FSM RESP: RespValid=1 and outputs are held stable. When RespReady=1, go to IDLE. Back-to-back requests lose one cycle: ReqReady is only high in IDLE.
- Latency: request accepted at edge 0; a hit in group k gives RespValid high after edge k+2. With no hit and defaults, RespValid rises after edge 5.
- PMPUpdate asserted in SCAN: reset g to 0 and rescan. Any partial scan result is discarded.
- PMPUpdate asserted in RESP or IDLE: no effect.
- Access range: lo = ReqAdr and hi = lo + 2^Size - 1, both computed PA_BITS+1 wide. If hi[PA_BITS]=1 (wrap past the top of the address space), fault immediately in the first SCAN cycle with RespHit=0.
- Per-entry region [base, top), with the mode taken from cfg[4:3]:
  - OFF: never matches.
  - TOR: base = PMPAdr[i-1]<<2, or 0 for i=0; top = PMPAdr[i]<<2. If base ≥ top the entry is empty and never matches.
  - NA4/NAPOT: base = PMPAdr & ~mask, using the trailing-ones mask rule (NA4 = 4 bytes); size = mask+1 in bytes.
- Match classes:
  - any = (lo < top) && (hi ≥ base).
  - full = (lo ≥ base) && (hi < top).
  - The lowest-index entry with "any" wins.
- Decision:
  - Winner partial (any && !full): RespFault=1.
  - Winner full: RespFault = ~(perm for ReqType) when !ReqPrivM or cfg.L=1; otherwise RespFault=0.
  - No winner: RespFault = ~ReqPrivM.
- NAPOT top is computed as base + size in PA_BITS+1 width, so a whole-space NAPOT entry does not wrap.

Decomposition:
- Package cvw (or pmp_pkg): PMP_OFF/TOR/NA4/NAPOT mode codes, and the access-type bit positions.
- Sub-module pmp_range_lane: combinational, one per lane. Inputs are lo, hi, cfg, PMPAdr[i], PMPAdr[i-1] and IsEntry0. Outputs are AnyMatch, FullMatch and the L/X/W/R permission bits.
- The top module holds the FSM, group counter, request latch, lane mux from the packed arrays, priority encoder and result register.

Test Plan:
- Entry0 NAPOT at 0x8000_0000 size 4 KiB, RWX, U-mode 8-byte read at 0x8000_0FF8 → RespFault=0, RespHit=1, RespIdx=0, RespValid after edge 2.
- Entry3 NA4 at 0x0C, R only, U-mode 8-byte read at 0x8 → partial match, RespFault=1, RespIdx=3.
- Entries 0..14 OFF, entry15 TOR [0x1000,0x2000) W only, U-mode 4-byte write at 0x1FFC → RespFault=0, RespIdx=15, RespValid after edge 5.
- All entries OFF: M-mode read at 0x0 → RespFault=0, RespHit=0; same request in U-mode → RespFault=1.
- Entry0 TOR 0x100 locked, R only, M-mode write to 0x80 → RespFault=1. Repeat with L=0 → RespFault=0.
- PMPUpdate pulsed in the second SCAN cycle → rescan restarts at group 0, latency extended by 2 cycles. Also assert reset mid-SCAN → RespValid=0 immediately, and IDLE with ReqReady=1 after release. Also issue ReqAdr=2^PA_BITS-4 with Size=3 → wrap, RespFault=1.
